// File: rtl/sm_dbg_port_ctrl_pkg.sv
// Shared definitions for the CPU debug-port sharing controller.
// Holds the controller state encoding and the well-known debug register indices.
package sm_dbg_port_ctrl_pkg;

    // Debug-port register index of the PC view.
    localparam int unsigned REG_PC            = 0;
    // regAddr value driven while the port is unused.
    localparam int unsigned DEFAULT_IDLE_ADDR = REG_PC;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOST     = 2'd1,
        ST_SCAN_CAP = 2'd2,
        ST_SCAN_OUT = 2'd3
    } dbgState_t;

endpackage

// File: rtl/sm_dbg_port_ctrl.sv
// Shares the CPU's single debug read port between a host requester and a
// register-range scanner that streams (addr, data) entries over valid/ready.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   regAddr / regData      debug read address out (registered), data in (same cycle)
//   host_req/host_addr     host single-register read request
//   host_ack/host_data     one-cycle completion pulse and captured value
//   scan_start             start a scan (only honoured in IDLE, host has priority)
//   scan_busy/scan_done    scan in progress / one-cycle end-of-scan pulse
//   out_valid/out_ready    scan entry stream handshake
//   out_addr/out_data      scan entry payload
module sm_dbg_port_ctrl
    import sm_dbg_port_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_FIRST = 0,
    parameter int unsigned REG_LAST  = 31,
    parameter int unsigned IDLE_ADDR = DEFAULT_IDLE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] regAddr,
    input  logic [DATA_W-1:0] regData,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_data,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(REG_FIRST);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(REG_LAST);
    localparam logic [ADDR_W-1:0] IDLE_A  = ADDR_W'(IDLE_ADDR);

    dbgState_t         state, stateNxt;
    logic              retScan, retScanNxt;   // host access returns to SCAN_CAP
    logic [ADDR_W-1:0] idx, idxNxt;
    logic [ADDR_W-1:0] regAddrNxt;
    logic              hostAckNxt;
    logic [DATA_W-1:0] hostDataNxt;
    logic              scanBusyNxt;
    logic              scanDoneNxt;
    logic              outValidNxt;
    logic [ADDR_W-1:0] outAddrNxt;
    logic [DATA_W-1:0] outDataNxt;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            retScan   <= 1'b0;
            idx       <= FIRST_A;
            regAddr   <= IDLE_A;
            host_ack  <= 1'b0;
            host_data <= '0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= stateNxt;
            retScan   <= retScanNxt;
            idx       <= idxNxt;
            regAddr   <= regAddrNxt;
            host_ack  <= hostAckNxt;
            host_data <= hostDataNxt;
            scan_busy <= scanBusyNxt;
            scan_done <= scanDoneNxt;
            out_valid <= outValidNxt;
            out_addr  <= outAddrNxt;
            out_data  <= outDataNxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNxt    = state;
        retScanNxt  = retScan;
        idxNxt      = idx;
        regAddrNxt  = regAddr;
        hostAckNxt  = 1'b0;
        hostDataNxt = host_data;
        scanBusyNxt = scan_busy;
        scanDoneNxt = 1'b0;
        outValidNxt = out_valid;
        outAddrNxt  = out_addr;
        outDataNxt  = out_data;

        unique case (state)
            ST_IDLE: begin
                // Host wins ties; scan_start is not remembered.
                if (host_req) begin
                    regAddrNxt = host_addr;
                    retScanNxt = 1'b0;
                    stateNxt   = ST_HOST;
                end else if (scan_start) begin
                    idxNxt      = FIRST_A;
                    regAddrNxt  = FIRST_A;
                    scanBusyNxt = 1'b1;
                    stateNxt    = ST_SCAN_CAP;
                end
            end
            ST_HOST: begin
                hostDataNxt = regData;
                hostAckNxt  = 1'b1;
                if (retScan) begin
                    regAddrNxt = idx;
                    stateNxt   = ST_SCAN_CAP;
                end else begin
                    regAddrNxt = IDLE_A;
                    stateNxt   = ST_IDLE;
                end
            end
            ST_SCAN_CAP: begin
                outAddrNxt  = regAddr;
                outDataNxt  = regData;
                outValidNxt = 1'b1;
                stateNxt    = ST_SCAN_OUT;
            end
            ST_SCAN_OUT: begin
                if (out_valid && out_ready) begin
                    outValidNxt = 1'b0;
                    if (idx == LAST_A) begin
                        scanBusyNxt = 1'b0;
                        scanDoneNxt = 1'b1;
                        regAddrNxt  = IDLE_A;
                        stateNxt    = ST_IDLE;
                    end else begin
                        // Waiting host gets one slot between entries.
                        idxNxt = idx + ADDR_W'(1);
                        if (host_req) begin
                            regAddrNxt = host_addr;
                            retScanNxt = 1'b1;
                            stateNxt   = ST_HOST;
                        end else begin
                            regAddrNxt = idx + ADDR_W'(1);
                            stateNxt   = ST_SCAN_CAP;
                        end
                    end
                end
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

endmodule
